// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop line synchroniser, 3-sample majority vote
// per bit, false-start and break suppression, parity/framing flags, 1-clk strobe.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_rx,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] C_DEC  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic                   rx_meta, rxs;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic [1:0]             samp;
  logic [IW-1:0]          bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr_r, ferr_r;
  logic                   maj, dec, wrap;

  // The third vote is the live sample taken on the decision tick itself.
  assign maj    = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
  assign dec    = i_clk_rx && (cnt == C_DEC);
  assign wrap   = i_clk_rx && (cnt == C_LAST);
  assign o_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      armed        <= 1'b0;
      cnt          <= '0;
      samp         <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      perr_r       <= 1'b0;
      ferr_r       <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      if (state == IDLE) begin
        if (i_clk_rx && rxs) armed <= 1'b1;
        if (armed && !rxs) begin
          state    <= START;
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          perr_r   <= 1'b0;
          ferr_r   <= 1'b0;
        end
      end else begin
        if (i_clk_rx) begin
          cnt <= (cnt == C_LAST) ? '0 : cnt + 1'b1;
          if (cnt == C_S0) samp[0] <= rxs;
          if (cnt == C_S1) samp[1] <= rxs;
        end
        case (state)
          START: begin
            if (dec && maj)  state <= IDLE;
            else if (wrap)   state <= DATA;
          end
          DATA: begin
            if (dec) shreg[bit_idx] <= maj;
            if (wrap) begin
              if (bit_idx == I_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
              else                   bit_idx <= bit_idx + 1'b1;
            end
          end
          PARITY: begin
            if (dec)  perr_r <= maj ^ (^shreg) ^ PAR_ODD;
            if (wrap) state <= STOP;
          end
          STOP: begin
            if (dec) begin
              if (!maj) ferr_r <= 1'b1;
              // Leave mid-bit so a start edge right after the stop bit is caught.
              if (stop_idx == STOP_LAST) begin
                state        <= IDLE;
                o_rx_data    <= shreg;
                o_parity_err <= perr_r;
                o_frame_err  <= ferr_r | ~maj;
                o_rx_valid   <= 1'b1;
                if (ferr_r || !maj) armed <= 1'b0;
              end
            end
            if (wrap) stop_idx <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
